// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, data-memory waits and timeout.
// Optional stall-cycle performance counter enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_UsesRt,
  input  logic       EX_MemRead,
  input  logic [4:0] EX_RegDest,
  input  logic       EX_BranchTaken,
  input  logic       MEM_MemAccess,
  input  logic       MEM_Ready,
  output logic       PC_Write,
  output logic       IFtoID_Write,
  output logic       IFtoID_Flush,
  output logic       IDtoEX_Write,
  output logic       IDtoEX_Flush,
  output logic       EXtoMEM_Write,
  output logic       MEMtoWB_Flush,
  output logic       mem_error,
  output logic [1:0] ctrl_state
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  // Control vector order: PC_W, IFID_W, IFID_F, IDEX_W, IDEX_F, EXMEM_W, MEMWB_F
  localparam logic [6:0] CTL_NORMAL = 7'b1101010;
  localparam logic [6:0] CTL_FREEZE = 7'b0000001;
  localparam logic [6:0] CTL_BRANCH = 7'b1111110;
  localparam logic [6:0] CTL_LU     = 7'b0001110;
  localparam logic [6:0] CTL_RESET  = 7'b0010101;

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_error_q, mem_error_d;
  logic       mem_stall_s;
  logic       lu_hazard_s;
  logic [6:0] ctl_s;

  assign mem_stall_s = MEM_MemAccess & ~MEM_Ready;
  assign lu_hazard_s = EX_MemRead && (EX_RegDest != 5'd0) &&
                       ((EX_RegDest == ID_rs) || (ID_UsesRt && (EX_RegDest == ID_rt)));

  // Pipeline register enables/flushes by priority; combinational so they act in the same cycle
  always_comb begin
    ctl_s = CTL_NORMAL;
    if (!rst) begin
      ctl_s = CTL_RESET;
    end else if (state_q == ST_ERROR) begin
      ctl_s = CTL_FREEZE;
    end else if (mem_stall_s) begin
      ctl_s = CTL_FREEZE;
    end else if (EX_BranchTaken) begin
      ctl_s = CTL_BRANCH;
    end else if (lu_hazard_s) begin
      ctl_s = CTL_LU;
    end else begin
      ctl_s = CTL_NORMAL;
    end
  end

  assign {PC_Write, IFtoID_Write, IFtoID_Flush, IDtoEX_Write,
          IDtoEX_Flush, EXtoMEM_Write, MEMtoWB_Flush} = ctl_s;

  // Memory-wait FSM next state and wait counter
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_error_d = mem_error_q;
    case (state_q)
      ST_RUN: begin
        if (mem_stall_s) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else begin
          wait_cnt_d = 8'd0;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_stall_s) begin
          if (wait_cnt_q == TIMEOUT_C) begin
            state_d     = ST_ERROR;
            mem_error_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end
      end
      ST_ERROR: begin
        state_d     = ST_ERROR;
        mem_error_d = 1'b1;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  // FSM state, wait counter and sticky error registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 8'd0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
    end
  end

  assign ctrl_state = state_q;
  assign mem_error  = mem_error_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Saturating count of cycles in which the PC is held, error cycles included
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!PC_Write && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // Stall-cycle counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT=4): directed vectors, negedge monitor.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] ID_rs, ID_rt, EX_RegDest;
  logic       ID_UsesRt, EX_MemRead, EX_BranchTaken, MEM_MemAccess, MEM_Ready;
  logic       PC_Write, IFtoID_Write, IFtoID_Flush, IDtoEX_Write, IDtoEX_Flush;
  logic       EXtoMEM_Write, MEMtoWB_Flush, mem_error;
  logic [1:0] ctrl_state;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  // {PC_W, IFID_W, IFID_F, IDEX_W, IDEX_F, EXMEM_W, MEMWB_F}
  localparam logic [6:0] NRM = 7'b1101010;
  localparam logic [6:0] STL = 7'b0000001;
  localparam logic [6:0] BRN = 7'b1111110;
  localparam logic [6:0] LUH = 7'b0001110;
  localparam logic [6:0] RSV = 7'b0010101;

  typedef struct packed {
    logic [6:0] ctl;
    logic [1:0] st;
    logic       err;
    int         id;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_RegDest(EX_RegDest), .EX_BranchTaken(EX_BranchTaken),
    .MEM_MemAccess(MEM_MemAccess), .MEM_Ready(MEM_Ready),
    .PC_Write(PC_Write), .IFtoID_Write(IFtoID_Write), .IFtoID_Flush(IFtoID_Flush),
    .IDtoEX_Write(IDtoEX_Write), .IDtoEX_Flush(IDtoEX_Flush),
    .EXtoMEM_Write(EXtoMEM_Write), .MEMtoWB_Flush(MEMtoWB_Flush),
    .mem_error(mem_error), .ctrl_state(ctrl_state)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expectation per cycle, compared mid-cycle
  always @(negedge clk) begin
    exp_t e;
    logic [6:0] act;
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      act = {PC_Write, IFtoID_Write, IFtoID_Flush, IDtoEX_Write,
             IDtoEX_Flush, EXtoMEM_Write, MEMtoWB_Flush};
      checks++;
      if (act !== e.ctl) begin
        failures++;
        $display("FAIL ctl vec%0d: got %b want %b", e.id, act, e.ctl);
      end
      checks++;
      if (ctrl_state !== e.st) begin
        failures++;
        $display("FAIL state vec%0d: got %0d want %0d", e.id, ctrl_state, e.st);
      end
      checks++;
      if (mem_error !== e.err) begin
        failures++;
        $display("FAIL mem_error vec%0d: got %b want %b", e.id, mem_error, e.err);
      end
    end
  end

  int vec_id = 0;

  task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic ur, input logic mr, input logic [4:0] rd,
                      input logic br, input logic ma, input logic rdy,
                      input logic [6:0] ectl, input logic [1:0] est, input logic eerr);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ID_rs = rs; ID_rt = rt; ID_UsesRt = ur; EX_MemRead = mr;
    EX_RegDest = rd; EX_BranchTaken = br; MEM_MemAccess = ma; MEM_Ready = rdy;
    e.ctl = ectl; e.st = est; e.err = eerr; e.id = vec_id;
    sb_q.push_back(e);
    vec_id++;
  endtask

  initial begin
    rst = 1'b0; ID_rs = 5'd0; ID_rt = 5'd0; ID_UsesRt = 1'b0; EX_MemRead = 1'b0;
    EX_RegDest = 5'd0; EX_BranchTaken = 1'b0; MEM_MemAccess = 1'b0; MEM_Ready = 1'b0;
    //    rst  rs     rt     ur    mr    rd     br    ma    rdy   ctl  st     err
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, RSV, 2'd0, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NRM, 2'd0, 1'b0);
    // load-use on rs, then back to normal
    step(1'b1, 5'd8, 5'd3, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, LUH, 2'd0, 1'b0);
    step(1'b1, 5'd8, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, NRM, 2'd0, 1'b0);
    // $0 destination and unused rt never stall; used rt does
    step(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, NRM, 2'd0, 1'b0);
    step(1'b1, 5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, NRM, 2'd0, 1'b0);
    step(1'b1, 5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, LUH, 2'd0, 1'b0);
    // branch wins over load-use
    step(1'b1, 5'd8, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, BRN, 2'd0, 1'b0);
    // 3-cycle memory wait
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, STL, 2'd0, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, STL, 2'd1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, STL, 2'd1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NRM, 2'd1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NRM, 2'd0, 1'b0);
    // branch held during stall, honoured on release
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, STL, 2'd0, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, BRN, 2'd1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NRM, 2'd0, 1'b0);
    // timeout: 5 low cycles with MEM_TIMEOUT=4
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, STL, 2'd0, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, STL, 2'd1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, STL, 2'd1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, STL, 2'd1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, STL, 2'd1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, STL, 2'd2, 1'b1);
    step(1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, STL, 2'd2, 1'b1);
    // reset clears error
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, RSV, 2'd0, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NRM, 2'd0, 1'b0);
    // reset mid-wait, then exactly 4 low cycles complete without error
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, STL, 2'd0, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, STL, 2'd1, 1'b0);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, RSV, 2'd0, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, STL, 2'd0, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, STL, 2'd1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, STL, 2'd1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, STL, 2'd1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NRM, 2'd1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NRM, 2'd0, 1'b0);

    @(posedge clk);
    #1;
`ifdef PIPE_PERF_CNT_EN
    checks++;
    if (stall_cycles !== 32'd4) begin
      failures++;
      $display("FAIL stall_cycles: got %0d want 4", stall_cycles);
    end
`endif
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
